// File: rtl/ov7670_capture_ctrl_if.sv
// Signal bundle between the OV7670 capture controller and its surroundings:
// camera byte stream and syncs, software control, and the pixel write port.
interface ov7670_capture_ctrl_if #(
    parameter int ADDR_W = 19
);
    logic [7:0]        D;
    logic              HREF;
    logic              VSYNC;
    logic              START;
    logic              ABORT;
    logic              CONTINUOUS;
    logic              o_WE;
    logic [ADDR_W-1:0] o_ADDR;
    logic [15:0]       o_DATA;
    logic              o_BUSY;
    logic              o_FRAME_DONE;
    logic              o_LINE_ERR;
    logic [7:0]        o_FRAME_CNT;

    // Camera/software side: drives the stream and control, receives writes.
    modport master (
        output D, HREF, VSYNC, START, ABORT, CONTINUOUS,
        input  o_WE, o_ADDR, o_DATA, o_BUSY, o_FRAME_DONE, o_LINE_ERR, o_FRAME_CNT
    );

    // Controller side.
    modport slave (
        input  D, HREF, VSYNC, START, ABORT, CONTINUOUS,
        output o_WE, o_ADDR, o_DATA, o_BUSY, o_FRAME_DONE, o_LINE_ERR, o_FRAME_CNT
    );
endinterface

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 frame-capture controller (PCLK domain). Aligns to a VSYNC falling
// edge, pairs RGB565 bytes into pixels, writes each at row*H_PIXELS+col and
// flags line/frame geometry errors.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | disarmed, waiting for START
// S_WAIT_VS | armed, waiting for VSYNC falling edge (frame start)
// S_CAPTURE | pairing bytes and issuing pixel writes
// S_DONE    | one-cycle end-of-frame, frame-done pulse visible
module ov7670_capture_ctrl #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int ADDR_W   = 19
) (
    input  logic                  PCLK,
    input  logic                  RST,
    ov7670_capture_ctrl_if.slave  bus
);
    localparam int COL_W = $clog2(H_PIXELS + 1);
    localparam int ROW_W = $clog2(V_LINES + 1);
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_PIXELS);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(V_LINES);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_LINES - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VS,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              vs_q, vs_d;
    logic              href_q, href_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;

    logic vs_fall, vs_rise, href_fall;

    assign vs_fall   = vs_q & ~bus.VSYNC;
    assign vs_rise   = ~vs_q & bus.VSYNC;
    assign href_fall = href_q & ~bus.HREF;

    // Next-state and datapath decode; ABORT is applied last so it overrides everything.
    always_comb begin
        state_d = state_q;
        vs_d    = bus.VSYNC;
        href_d  = bus.HREF;
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    state_d = S_WAIT_VS;
                    err_d   = 1'b0;
                end
            end
            S_WAIT_VS: begin
                if (vs_fall) begin
                    state_d = S_CAPTURE;
                    col_d   = '0;
                    row_d   = '0;
                    base_d  = '0;
                    phase_d = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (vs_rise) begin
                    // An unfinished line (HREF still high) makes the frame short.
                    if ((row_q != ROW_MAX) || bus.HREF) begin
                        err_d = 1'b1;
                    end
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end else if (bus.HREF) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        hi_d = bus.D;
                    end else begin
                        if ((col_q < COL_MAX) && (row_q < ROW_MAX)) begin
                            we_d   = 1'b1;
                            addr_d = base_q + ADDR_W'(col_q);
                            data_d = {hi_q, bus.D};
                        end else begin
                            err_d = 1'b1;
                        end
                        if (col_q != COL_MAX) begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end else if (href_fall) begin
                    if ((col_q != COL_MAX) || phase_q) begin
                        err_d = 1'b1;
                    end
                    col_d   = '0;
                    phase_d = 1'b0;
                    if (row_q != ROW_MAX) begin
                        row_d = row_q + ROW_W'(1);
                    end
                    // Base tracks row*H_PIXELS and stops at the last line's base.
                    if (row_q < ROW_LAST) begin
                        base_d = base_q + LINE_STEP;
                    end
                end
            end
            S_DONE: begin
                state_d = bus.CONTINUOUS ? S_WAIT_VS : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.ABORT) begin
            state_d = S_IDLE;
            we_d    = 1'b0;
            addr_d  = addr_q;
            data_d  = data_q;
            done_d  = 1'b0;
            err_d   = err_q;
            cnt_d   = cnt_q;
        end
    end

    // State and registered outputs, asynchronously cleared.
    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            vs_q    <= 1'b0;
            href_q  <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            phase_q <= 1'b0;
            hi_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vs_q    <= vs_d;
            href_q  <= href_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            phase_q <= phase_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_WE         = we_q;
    assign bus.o_ADDR       = addr_q;
    assign bus.o_DATA       = data_q;
    assign bus.o_BUSY       = (state_q != S_IDLE);
    assign bus.o_FRAME_DONE = done_q;
    assign bus.o_LINE_ERR   = err_q;
    assign bus.o_FRAME_CNT  = cnt_q;
endmodule
